// File: rtl/seg_display_driver_if.sv
// Display driver port bundle: CPU-side sources and select in, board anode/segment drive out.
// The driver itself takes the slave view; whatever feeds it takes the master view.
interface seg_display_driver_if;
    logic [1:0]  sel;
    logic [31:0] leddata;
    logic [31:0] count_cycle;
    logic [31:0] count_branch;
    logic [31:0] count_jmp;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output sel, leddata, count_cycle, count_branch, count_jmp, blank_lz,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  sel, leddata, count_cycle, count_branch, count_jmp, blank_lz,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg_display_driver.sv
// Multiplexed 8-digit hex display driver with a prescaled scan, per-slot anode blanking
// and leading-zero suppression. The value shown is frozen once per frame so it never tears.
module seg_display_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic               clk,
    input  logic               clr,
    seg_display_driver_if.slave bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   snap_q, snap_d;
    logic [1:0]    sel_q, sel_d;
    logic          frame_done_q, frame_done_d;

    logic [31:0]   src;
    logic [3:0]    nibble;
    logic          upper_zero;
    logic          lz_blank;
    logic          blank_win;

    always_comb begin
        src = bus.leddata;
        unique case (bus.sel)
            2'b00: src = bus.leddata;
            2'b01: src = bus.count_cycle;
            2'b10: src = bus.count_branch;
            2'b11: src = bus.count_jmp;
        endcase
    end

    // The snapshot and the select that produced it are taken together on the 7->0 wrap.
    always_comb begin
        presc_d      = presc_q + PW'(1);
        idx_d        = idx_q;
        snap_d       = snap_q;
        sel_d        = sel_q;
        frame_done_d = 1'b0;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                snap_d       = src;
                sel_d        = bus.sel;
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q      <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            sel_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    // With no blanking window the comparison against zero would be constant, so drop it.
    if (BLANK_CYC > 0) begin : g_blank
        localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYC);
        assign blank_win = presc_q < BLANK_LIM;
    end else begin : g_noblank
        assign blank_win = 1'b0;
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign nibble     = snap_q[{idx_q, 2'b00} +: 4];
    assign upper_zero = (snap_q >> {idx_q, 2'b00}) == 32'd0;
    assign lz_blank   = bus.blank_lz && (idx_q != 3'd0) && upper_zero;

    assign bus.seg        = lz_blank ? 7'h7F : hex7(nibble);
    assign bus.an         = blank_win ? 8'hFF : ~(8'h01 << idx_q);
    assign bus.dp         = ~((idx_q == 3'd0) && (sel_q != 2'b00) && !blank_win);
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench: two drivers (SCAN_DIV=4/BLANK_CYC=1 and SCAN_DIV=2/BLANK_CYC=0) share clk/clr;
// stimulus pushes per-cycle expectations, a negedge monitor pops and compares them.
module tb_seg_display_driver;

    logic clk;
    logic clr;

    seg_display_driver_if bus_a ();
    seg_display_driver_if bus_b ();

    seg_display_driver #(.SCAN_DIV(4), .BLANK_CYC(1)) dut_a (
        .clk (clk),
        .clr (clr),
        .bus (bus_a)
    );

    seg_display_driver #(.SCAN_DIV(2), .BLANK_CYC(0)) dut_b (
        .clk (clk),
        .clr (clr),
        .bus (bus_b)
    );

    typedef struct {
        string      name;
        bit         dut;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_pass;
    int   k;

    logic [6:0] exp_a [8];
    logic [6:0] nxt_a [8];
    logic       exp_dp0_a;
    logic       nxt_dp0_a;
    logic [6:0] tab_b [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_an(input int kk, input int sd, input int bc);
        int presc;
        int idx;
        presc = kk % sd;
        idx   = (kk / sd) % 8;
        if (presc < bc) return 8'hFF;
        return ~(8'h01 << idx);
    endfunction

    task automatic applyStimulus(input logic [1:0] s, input logic [31:0] ld, input logic [31:0] cc,
                                 input logic [31:0] cb, input logic [31:0] cj, input logic blz);
        bus_a.sel          = s;
        bus_a.leddata      = ld;
        bus_a.count_cycle  = cc;
        bus_a.count_branch = cb;
        bus_a.count_jmp    = cj;
        bus_a.blank_lz     = blz;
    endtask

    task automatic checkOutput();
        exp_t e;
        int   ia;
        int   ib;
        ia    = (k / 4) % 8;
        e.name = $sformatf("A k=%0d", k);
        e.dut  = 1'b0;
        e.an   = model_an(k, 4, 1);
        e.seg  = exp_a[ia];
        e.dp   = (ia == 0 && e.an != 8'hFF) ? exp_dp0_a : 1'b1;
        e.fd   = (k > 0) && (k % 32 == 0);
        sb_q.push_back(e);
        ib    = (k / 2) % 8;
        e.name = $sformatf("B k=%0d", k);
        e.dut  = 1'b1;
        e.an   = model_an(k, 2, 0);
        e.seg  = (k >= 16) ? tab_b[ib] : 7'h40;
        e.dp   = 1'b1;
        e.fd   = (k > 0) && (k % 16 == 0);
        sb_q.push_back(e);
    endtask

    // Asynchronous reset must force the documented reset outputs without waiting for a clock edge.
    task automatic checkResetState();
        n_checks++;
        if ({bus_a.an, bus_a.seg, bus_a.dp, bus_a.frame_done} === {8'hFF, 7'h40, 1'b1, 1'b0}) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL reset state: got an=%h seg=%h dp=%b fd=%b, expected an=ff seg=40 dp=1 fd=0",
                     bus_a.an, bus_a.seg, bus_a.dp, bus_a.frame_done);
        end
    endtask

    // Bounded wait for the next frame_done pulse; running out of cycles is a failure.
    task automatic waitFrameDone(input int maxCyc);
        int c;
        bit seen;
        seen = 1'b0;
        for (c = 0; c < maxCyc && !seen; c++) begin
            @(posedge clk);
            #1;
            if (bus_a.frame_done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL frame_done wait expired after %0d cycles", maxCyc);
        end
    endtask

    // One clock step; k counts rising edges since the last reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!clr) k++;
        if (k > 0 && k % 32 == 0) begin
            exp_a     = nxt_a;
            exp_dp0_a = nxt_dp0_a;
        end
    endtask

    task automatic run_to(input int target);
        while (k < target) begin
            tick();
            checkOutput();
        end
    endtask

    task automatic reset_model();
        k         = 0;
        exp_a     = '{default: 7'h40};
        exp_dp0_a = 1'b1;
    endtask

    initial begin
        exp_t       e;
        logic [7:0] act_an;
        logic [6:0] act_seg;
        logic       act_dp;
        logic       act_fd;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.dut) begin
                    act_an = bus_b.an; act_seg = bus_b.seg; act_dp = bus_b.dp; act_fd = bus_b.frame_done;
                end else begin
                    act_an = bus_a.an; act_seg = bus_a.seg; act_dp = bus_a.dp; act_fd = bus_a.frame_done;
                end
                n_checks++;
                if ({act_an, act_seg, act_dp, act_fd} === {e.an, e.seg, e.dp, e.fd}) begin
                    n_pass++;
                end else begin
                    $display("[TB] FAIL %s: got an=%h seg=%h dp=%b fd=%b, expected an=%h seg=%h dp=%b fd=%b",
                             e.name, act_an, act_seg, act_dp, act_fd, e.an, e.seg, e.dp, e.fd);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clr      = 1'b1;
        applyStimulus(2'b00, 32'h89ABCDEF, 32'h0, 32'h0, 32'h0, 1'b0);
        bus_b.sel          = 2'b00;
        bus_b.leddata      = 32'h76543210;
        bus_b.count_cycle  = 32'h0;
        bus_b.count_branch = 32'h0;
        bus_b.count_jmp    = 32'h0;
        bus_b.blank_lz     = 1'b0;
        tab_b     = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        nxt_a     = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
        nxt_dp0_a = 1'b1;
        reset_model();

        repeat (3) begin
            tick();
            checkOutput();
        end
        tick();
        clr = 1'b0;
        checkOutput();
        run_to(10);

        // Reset in the middle of digit 2 of the first frame.
        tick();
        clr = 1'b1;
        #1;
        checkResetState();
        reset_model();
        checkOutput();
        tick();
        checkOutput();
        tick();
        clr = 1'b0;
        checkOutput();

        // Frame 1 shows 89ABCDEF; queue 00000120 for frame 2.
        run_to(39);
        tick();
        applyStimulus(2'b00, 32'h00000120, 32'h0, 32'h0, 32'h0, 1'b0);
        nxt_a = '{7'h40, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        checkOutput();

        // Leading-zero suppression takes effect live, mid-frame.
        run_to(79);
        tick();
        applyStimulus(2'b00, 32'h00000120, 32'h0, 32'h0, 32'h0, 1'b1);
        exp_a = '{7'h40, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        nxt_a = exp_a;
        checkOutput();
        applyStimulus(2'b00, 32'h00000000, 32'h0, 32'h0, 32'h0, 1'b1);
        nxt_a = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

        run_to(99);
        tick();
        applyStimulus(2'b00, 32'h11111111, 32'h0, 32'h0, 32'h0, 1'b0);
        exp_a = '{default: 7'h40};
        nxt_a = '{default: 7'h79};
        checkOutput();

        // Source change while digit 3 is lit must not reach digits 4..7 this frame.
        run_to(139);
        tick();
        applyStimulus(2'b00, 32'h22222222, 32'h0, 32'h0, 32'h0, 1'b0);
        nxt_a = '{default: 7'h24};
        checkOutput();

        run_to(169);
        tick();
        applyStimulus(2'b10, 32'h22222222, 32'h33, 32'h5, 32'h44, 1'b0);
        nxt_a     = '{7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        nxt_dp0_a = 1'b0;
        checkOutput();

        // Select back to leddata while digit 0 of the counter frame is still lit.
        run_to(192);
        tick();
        applyStimulus(2'b00, 32'h22222222, 32'h33, 32'h5, 32'h44, 1'b0);
        nxt_a     = '{default: 7'h24};
        nxt_dp0_a = 1'b1;
        checkOutput();

        run_to(229);
        tick();
        applyStimulus(2'b11, 32'h22222222, 32'h33, 32'h5, 32'h000000C4, 1'b0);
        nxt_a     = '{7'h19, 7'h46, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        nxt_dp0_a = 1'b0;
        checkOutput();

        run_to(259);
        tick();
        applyStimulus(2'b01, 32'h22222222, 32'h000000D3, 32'h5, 32'h000000C4, 1'b0);
        nxt_a     = '{7'h30, 7'h21, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        nxt_dp0_a = 1'b0;
        checkOutput();

        run_to(321);
        waitFrameDone(40);
        @(negedge clk);
        #1;
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
